// File: rtl/aes_ctr_engine.sv
`timescale 1ns/1ps
// aes_ctr_engine
//
// Counter-mode sequencer wrapped around an external pipelined AES-256 core
// (aes_encrypt). It issues successive 128-bit counter blocks with a held key,
// carries each block's plaintext alongside the core pipeline in a sideband
// delay line, XORs the returned keystream with that plaintext and queues the
// result in an output FIFO. The core has no stall input, so the FIFO never
// refuses a write: a block is only accepted when a FIFO slot is already
// reserved for it (credit = in-flight blocks + queued results < DEPTH).
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, iv, key_in,  begin a message of len 128-bit blocks; sampled only
//   len                 in IDLE
//   busy                high while a message is running or draining
//   done                one-cycle pulse when the last result has left
//   in_valid/in_ready/  plaintext stream
//   in_data
//   out_valid/out_ready/ ciphertext stream; out_data is the registered
//   out_data            FIFO head
//   aes_data, aes_key   counter block and key driven into aes_encrypt
//   aes_cypher          keystream returned LATENCY edges after sampling
module aes_ctr_engine #(
  parameter int LATENCY = 14,
  parameter int DEPTH   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] iv,
  input  logic [255:0] key_in,
  input  logic [31:0]  len,
  output logic         busy,
  output logic         done,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [127:0] aes_data,
  output logic [255:0] aes_key,
  input  logic [127:0] aes_cypher
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int INF_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_next;

  // Message bookkeeping; aes_data is the live counter register itself.
  logic [31:0] remaining;

  // Sideband delay line, aligned with the core pipeline.
  logic         sb_valid [LATENCY];
  logic [127:0] sb_data  [LATENCY];
  logic [INF_W-1:0] inflight;

  // Output FIFO.
  logic [127:0]     fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CNT_W-1:0] fifo_count;

  logic         accept;
  logic         push;
  logic         pop;
  logic [127:0] push_data;
  logic         credit_ok;

  // Credits use the registered FIFO count, so a pop only frees a slot for
  // acceptance in the following cycle.
  assign credit_ok = (32'(inflight) + 32'(fifo_count)) < 32'(DEPTH);
  assign in_ready  = (state == RUN) && (remaining != '0) && credit_ok;
  assign accept    = in_valid && in_ready;

  // The last sideband stage lines up with the core's output on this edge.
  assign push      = sb_valid[LATENCY-1];
  assign push_data = aes_cypher ^ sb_data[LATENCY-1];

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign rd_next   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned, which
    // would otherwise infer a latch.
    state_next = state;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = (len == '0) ? DRAIN : RUN;
      end
      RUN: begin
        if (accept && (remaining == 32'd1)) state_next = DRAIN;
      end
      DRAIN: begin
        if ((inflight == '0) && (fifo_count == '0)) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter, key and block count
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aes_data  <= '0;
      aes_key   <= '0;
      remaining <= '0;
    end else if ((state == IDLE) && start) begin
      aes_data  <= iv;
      aes_key   <= key_in;
      remaining <= len;
    end else if (accept) begin
      // The core sampled the current counter on this edge; move to the next
      // one. Natural 128-bit wrap takes all-ones to zero.
      aes_data  <= aes_data + 128'd1;
      remaining <= remaining - 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sideband delay line and in-flight count
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Clearing the valid bits discards whatever the core still holds.
      for (int i = 0; i < LATENCY; i++) begin
        sb_valid[i] <= 1'b0;
        sb_data[i]  <= '0;
      end
      inflight <= '0;
    end else begin
      sb_valid[0] <= accept;
      sb_data[0]  <= accept ? in_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_data[i]  <= sb_data[i-1];
      end
      unique case ({accept, push})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO with registered head
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the storage array is reset too, so no stale ciphertext from an
      // aborted message can ever reach out_data.
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_data   <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_next;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      // The entry written this edge becomes the head when it lands exactly
      // where the read pointer will point; otherwise read from storage.
      if (push && (wr_ptr == rd_next)) out_data <= push_data;
      else                             out_data <= fifo_mem[rd_next];
    end
  end

  // The credit scheme makes a write into a full FIFO impossible.
  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (fifo_count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_aes_ctr_engine.sv
`timescale 1ns/1ps
// Bench for aes_ctr_engine. A behavioural stand-in for aes_encrypt returns
// the NIST SP800-38A F.5.5 keystream blocks for the two NIST counter values
// under the NIST key, and a fixed non-linear mixing function otherwise.
// Expected results are queued at acceptance; a monitor pops and compares.
module tb_aes_ctr_engine;

  localparam int LATENCY = 14;
  localparam int DEPTH   = 16;

  localparam logic [255:0] NIST_KEY =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] NIST_IV = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] CTR1    = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] KS0     = 128'h0bdf7df1591716335e9a8b15c860c502;
  localparam logic [127:0] KS1     = 128'h5a6e699d536119065433863c8f657b94;
  localparam logic [127:0] PT0     = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT1     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT0     = 128'h601ec313775789a5b7a7f504bbf3d228;
  localparam logic [127:0] CT1     = 128'hf443e3ca4d62b59aca84e990cacaf5c5;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] iv;
  logic [255:0] key_in;
  logic [31:0]  len;
  logic         busy;
  logic         done;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [127:0] aes_data;
  logic [255:0] aes_key;
  logic [127:0] aes_cypher;

  aes_ctr_engine #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .iv         (iv),
    .key_in     (key_in),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .aes_data   (aes_data),
    .aes_key    (aes_key),
    .aes_cypher (aes_cypher)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Core stand-in: samples data/key on edge t, result sampled by the DUT on
  // edge t+LATENCY.
  // ---------------------------------------------------------------------------
  function automatic logic [127:0] core_fn(input logic [255:0] k, input logic [127:0] b);
    logic [31:0] m;
    if (k == NIST_KEY && b == NIST_IV) return KS0;
    if (k == NIST_KEY && b == CTR1)    return KS1;
    m = b[31:0] * 32'h9e3779b1;
    return {b[95:0], b[127:96]} ^ k[255:128] ^ ~k[127:0] ^ {4{m}};
  endfunction

  logic [127:0] core_pipe [LATENCY];
  always @(posedge clk) begin
    core_pipe[0] <= core_fn(aes_key, aes_data);
    for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign aes_cypher = core_pipe[LATENCY-1];

  // ---------------------------------------------------------------------------
  // Scoreboard and bookkeeping
  // ---------------------------------------------------------------------------
  int           n_tests = 0;
  int           n_fail  = 0;
  int unsigned  cyc = 0;
  int unsigned  pop_cyc = 0;
  int unsigned  prev_pop_cyc = 0;
  int unsigned  accept_cyc = 0;
  int           done_cnt = 0;
  logic [127:0] exp_q [$];
  logic [127:0] m_ctr;
  logic [255:0] m_key;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && done) done_cnt++;
    if (!rst && out_valid && out_ready) begin
      check("output_expected", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        check("out_data", out_data, exp_q.pop_front());
        prev_pop_cyc = pop_cyc;
        pop_cyc      = cyc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers; each starts and ends 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] s_iv, input logic [255:0] s_key,
                          input logic [31:0] s_len, input bit track);
    start  = 1'b1;
    iv     = s_iv;
    key_in = s_key;
    len    = s_len;
    tick();
    start  = 1'b0;
    if (track) begin
      m_ctr = s_iv;
      m_key = s_key;
    end
  endtask

  task automatic send_block(input logic [127:0] pt, input bit use_exp, input logic [127:0] exp);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = pt;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_wait", 128'(in_ready), 128'd1);
    if (in_ready) begin
      exp_q.push_back(use_exp ? exp : (core_fn(m_key, m_ctr) ^ pt));
      m_ctr = m_ctr + 128'd1;
    end
    tick();
    accept_cyc = cyc;
    in_valid   = 1'b0;
    in_data    = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("idle_reached", 128'(busy), 128'd0);
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int d0;
    int hits;
    int unsigned t0;
    rst       = 1'b1;
    start     = 1'b0;
    iv        = '0;
    key_in    = '0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    m_ctr     = '0;
    m_key     = '0;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",      128'(busy),      128'd0);
    check("rst_done",      128'(done),      128'd0);
    check("rst_in_ready",  128'(in_ready),  128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data",  out_data,        128'd0);
    check("rst_aes_data",  aes_data,        128'd0);
    check("rst_aes_key",   aes_key[127:0] | aes_key[255:128], 128'd0);
    tick();
    rst = 1'b0;
    tick();

    // NIST single block with latency and done.
    d0 = done_cnt;
    do_start(NIST_IV, NIST_KEY, 32'd1, 1'b1);
    check("aes_key_latched_hi", aes_key[255:128], NIST_KEY[255:128]);
    check("aes_key_latched_lo", aes_key[127:0],   NIST_KEY[127:0]);
    send_block(PT0, 1'b1, CT0);
    wait_idle(100);
    check("single_latency", 128'(pop_cyc - accept_cyc), 128'(LATENCY));
    check("single_done_once", 128'(done_cnt - d0), 128'd1);

    // NIST two blocks back-to-back.
    do_start(NIST_IV, NIST_KEY, 32'd2, 1'b1);
    send_block(PT0, 1'b1, CT0);
    send_block(PT1, 1'b1, CT1);
    wait_idle(100);
    check("b2b_spacing", 128'(pop_cyc - prev_pop_cyc), 128'd1);

    // 64 blocks with the sink stalled: credit limit stops acceptance.
    out_ready = 1'b0;
    t0 = cyc;
    do_start(128'h00112233445566778899aabbccddeeff,
             256'h0f0e0d0c0b0a09080706050403020100_1f1e1d1c1b1a19181716151413121110,
             32'd64, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      send_block({32'(i), ~32'(i), 32'(i) * 32'h01010101, 32'hc0ffee00 + 32'(i)}, 1'b0, '0);
    @(negedge clk);
    check("credit_stall", 128'(in_ready), 128'd0);
    while (cyc - t0 < 100) tick();
    @(negedge clk);
    check("credit_stall_held", 128'(in_ready),  128'd0);
    check("fifo_full_valid",   128'(out_valid), 128'd1);
    tick();
    out_ready = 1'b1;
    for (int i = DEPTH; i < 64; i++)
      send_block({32'(i), ~32'(i), 32'(i) * 32'h01010101, 32'hc0ffee00 + 32'(i)}, 1'b0, '0);
    wait_idle(500);

    // Counter wrap from all-ones to zero.
    do_start({128{1'b1}}, NIST_KEY, 32'd2, 1'b1);
    send_block('0, 1'b1, core_fn(NIST_KEY, {128{1'b1}}));
    send_block('0, 1'b1, core_fn(NIST_KEY, 128'd0));
    wait_idle(100);

    // Reset with five blocks in flight.
    do_start(128'h1234, {8{32'hdeadbeef}}, 32'd10, 1'b1);
    for (int i = 0; i < 5; i++) send_block(128'(i + 1), 1'b0, '0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_busy",      128'(busy),      128'd0);
    check("midrst_in_ready",  128'(in_ready),  128'd0);
    check("midrst_aes_data",  aes_data,        128'd0);
    exp_q.delete();
    repeat (3) tick();
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid || busy) hits++;
    end
    check("post_rst_quiet", 128'(hits), 128'd0);
    tick();
    do_start(NIST_IV, NIST_KEY, 32'd1, 1'b1);
    send_block(PT0, 1'b1, CT0);
    wait_idle(100);

    // Empty message.
    d0 = done_cnt;
    hits = 0;
    do_start(128'h5555, {8{32'h0badf00d}}, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (in_ready || out_valid) hits++;
    end
    tick();
    check("len0_no_traffic", 128'(hits), 128'd0);
    check("len0_done_once",  128'(done_cnt - d0), 128'd1);
    check("len0_idle",       128'(busy), 128'd0);
    check("len0_key",        aes_key[127:0], {4{32'h0badf00d}});

    // Start while busy is ignored.
    d0 = done_cnt;
    do_start(128'haaaa0000, {8{32'h13579bdf}}, 32'd1, 1'b1);
    do_start(128'hbbbb0000, {8{32'h2468ace0}}, 32'd5, 1'b0);
    check("busy_start_key", aes_key[255:128], {4{32'h13579bdf}});
    check("busy_start_iv",  aes_data,         128'haaaa0000);
    send_block(128'hfeedface, 1'b0, '0);
    wait_idle(100);
    check("busy_start_done_once", 128'(done_cnt - d0), 128'd1);
    check("busy_start_ctr",       aes_data,       128'haaaa0001);
    check("busy_start_key_kept",  aes_key[127:0], {4{32'h13579bdf}});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
